// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the UART frame receiver.
//   state_e      : frame parser states (HUNT/LEN/DATA/CHK, 2-bit encoding)
//   ERR_*        : err_code values reported alongside frame_err
//   SOF_DEFAULT  : default start-of-frame byte
package uart_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TO   = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_rx_timer.sv
// Inter-byte timeout counter for the frame receiver.
//   clk_i     : system clock
//   rst_ni    : asynchronous reset, active-low
//   clr_i     : synchronous clear (has priority over en_i)
//   en_i      : count one cycle
//   expire_o  : combinational, high when counting from TIMEOUT-1
module uart_frame_rx_timer #(
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned TO_BIT  = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_BIT-1:0] LAST = TO_BIT'(TIMEOUT - 1);

    logic [TO_BIT-1:0] cnt_q;

    assign expire_o = en_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + TO_BIT'(1);
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: pops bytes from the rx FIFO, hunts for SOF and decodes
// SOF | LEN | LEN payload bytes | CHK (CHK = XOR of LEN and payload).
// Payload is forwarded on a valid/ready stream; each frame ends in a one-cycle
// frame_ok or frame_err pulse.
//   clk, reset         : clock, asynchronous active-low reset
//   r_data, rx_empty   : head of rx FIFO / FIFO empty
//   rd_uart            : combinational pop strobe
//   m_data/m_valid/m_last/m_ready : payload stream (registered outputs)
//   frame_ok, frame_err: one-cycle result pulses
//   err_code           : reason for the last frame_err (1=LEN, 2=CHK, 3=timeout)
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int unsigned     DBIT    = 8,
    parameter int unsigned     MAX_LEN = 64,
    parameter logic [DBIT-1:0] SOF     = DBIT'(SOF_DEFAULT),
    parameter int unsigned     TIMEOUT = 50000,
    parameter int unsigned     TO_BIT  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DBIT-1:0] r_data,
    input  logic            rx_empty,
    output logic            rd_uart,
    output logic [DBIT-1:0] m_data,
    output logic            m_valid,
    output logic            m_last,
    input  logic            m_ready,
    output logic            frame_ok,
    output logic            frame_err,
    output logic [1:0]      err_code
);

    state_e          state_q;
    logic [DBIT-1:0] len_q;
    logic [DBIT-1:0] cnt_q;
    logic [DBIT-1:0] chk_q;
    logic [DBIT-1:0] m_data_q;
    logic            m_valid_q;
    logic            m_last_q;
    logic            frame_ok_q;
    logic            frame_err_q;
    logic [1:0]      err_code_q;

    logic            pop;
    logic            len_bad;
    logic [DBIT-1:0] cnt_inc;
    logic            last_byte;
    logic            to_clr;
    logic            to_en;
    logic            to_expire;

    // Pop gating also uses reset so nothing is consumed while held in reset.
    // In DATA a byte is only taken when the output register is free or draining.
    always_comb begin
        pop = 1'b0;
        if (reset && !rx_empty) begin
            if (state_q == ST_DATA) begin
                pop = !m_valid_q || m_ready;
            end else begin
                pop = 1'b1;
            end
        end
    end

    assign rd_uart   = pop;
    assign len_bad   = (r_data == '0) || (r_data > DBIT'(MAX_LEN));
    assign cnt_inc   = cnt_q + DBIT'(1);
    assign last_byte = (cnt_inc == len_q);

    // Timer runs only inside a frame and only while the FIFO is empty, so a
    // byte stalled by downstream backpressure never times the frame out.
    assign to_clr = pop || (state_q == ST_HUNT) || to_expire;
    assign to_en  = rx_empty && (state_q != ST_HUNT);

    uart_frame_rx_timer #(
        .TIMEOUT(TIMEOUT),
        .TO_BIT (TO_BIT)
    ) u_timer (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (to_clr),
        .en_i    (to_en),
        .expire_o(to_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_HUNT;
            len_q       <= '0;
            cnt_q       <= '0;
            chk_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;

            // Output register is independent of the parser state so payload
            // can keep draining after the frame result has been reported.
            if (pop && (state_q == ST_DATA)) begin
                m_data_q  <= r_data;
                m_valid_q <= 1'b1;
                m_last_q  <= last_byte;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end

            // Expiry needs rx_empty and a pop needs !rx_empty, so they never collide.
            if (to_expire) begin
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TO;
                state_q     <= ST_HUNT;
            end else begin
                case (state_q)
                    ST_HUNT: begin
                        if (pop && (r_data == SOF)) begin
                            state_q <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (pop) begin
                            if (len_bad) begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= ERR_LEN;
                                state_q     <= ST_HUNT;
                            end else begin
                                len_q   <= r_data;
                                chk_q   <= r_data;
                                cnt_q   <= '0;
                                state_q <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (pop) begin
                            chk_q <= chk_q ^ r_data;
                            cnt_q <= cnt_inc;
                            if (last_byte) begin
                                state_q <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (pop) begin
                            if (r_data == chk_q) begin
                                frame_ok_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= ERR_CHK;
                            end
                            state_q <= ST_HUNT;
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
`timescale 1ns/1ps
module tb_uart_frame_rx;

    localparam int unsigned DBIT    = 8;
    localparam int unsigned MAX_LEN = 64;
    localparam int unsigned TIMEOUT = 100;
    localparam int unsigned TO_BIT  = 16;
    localparam logic [7:0]  SOF_B   = 8'hA5;

    // Role of each byte in the stream, assigned when the stream is composed.
    typedef enum int {R_DROP, R_SOF, R_LEN, R_PAY, R_CHK} role_e;
    typedef struct {
        logic [7:0] b;
        role_e      r;
        logic       last;
        logic       good;
    } item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       rd_uart;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    uart_frame_rx #(
        .DBIT   (DBIT),
        .MAX_LEN(MAX_LEN),
        .SOF    (SOF_B),
        .TIMEOUT(TIMEOUT),
        .TO_BIT (TO_BIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .r_data   (r_data),
        .rx_empty (rx_empty),
        .rd_uart  (rd_uart),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    item_t      fifo[$];
    logic [7:0] pay_q[$];
    logic       last_q[$];
    logic [7:0] pl[$];

    int   errors = 0;
    int   checks = 0;
    int   hide_pct = 0;
    int   rdy_pct = 100;
    int   pay_pops = 0;
    logic mv_exp;
    logic ok_exp;
    logic err_exp;
    logic [1:0] code_exp;
    bit   in_frame;
    int   empty_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_inputs();
        bit hide;
        hide     = ($urandom_range(99) < hide_pct);
        m_ready  = ($urandom_range(99) < rdy_pct);
        rx_empty = hide || (fifo.size() == 0);
        r_data   = (fifo.size() != 0) ? fifo[0].b : 8'h00;
    endtask

    task automatic model_reset();
        fifo.delete();
        pay_q.delete();
        last_q.delete();
        mv_exp    = 1'b0;
        ok_exp    = 1'b0;
        err_exp   = 1'b0;
        code_exp  = 2'd0;
        in_frame  = 1'b0;
        empty_run = 0;
    endtask

    task automatic push_byte(input logic [7:0] b, input role_e r, input logic last, input logic good);
        item_t it;
        it.b = b; it.r = r; it.last = last; it.good = good;
        fifo.push_back(it);
    endtask

    // Frame from global payload pl; chk_ovr < 0 means send the correct checksum.
    task automatic push_frame(input int chk_ovr);
        logic [7:0] x;
        logic [7:0] c;
        x = 8'(pl.size());
        push_byte(SOF_B, R_SOF, 1'b0, 1'b1);
        push_byte(x, R_LEN, 1'b0, 1'b1);
        for (int i = 0; i < pl.size(); i++) begin
            x = x ^ pl[i];
            push_byte(pl[i], R_PAY, (i == pl.size() - 1), 1'b1);
        end
        c = (chk_ovr < 0) ? x : 8'(chk_ovr);
        push_byte(c, R_CHK, 1'b0, (c == x));
    endtask

    task automatic rand_payload(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    // One clock: predict this edge from the stream rules, then check what the DUT shows after it.
    task automatic cycle();
        logic  exp_rd;
        logic  accept;
        logic  nok;
        logic  nerr;
        item_t it;
        exp_rd = 1'b0;
        if (!rx_empty) exp_rd = (fifo[0].r == R_PAY) ? (!mv_exp || m_ready) : 1'b1;
        check("rd_uart", rd_uart, exp_rd);
        accept = mv_exp && m_ready;
        nok  = 1'b0;
        nerr = 1'b0;
        it.r = R_DROP;
        if (exp_rd) begin
            it = fifo.pop_front();
            empty_run = 0;
            case (it.r)
                R_SOF: in_frame = 1'b1;
                R_LEN: if (!it.good) begin nerr = 1'b1; code_exp = 2'd1; in_frame = 1'b0; end
                R_PAY: pay_pops++;
                R_CHK: begin
                    in_frame = 1'b0;
                    if (it.good) nok = 1'b1;
                    else begin nerr = 1'b1; code_exp = 2'd2; end
                end
                default: ;
            endcase
        end else if (in_frame && rx_empty) begin
            if (empty_run == int'(TIMEOUT) - 1) begin
                nerr = 1'b1; code_exp = 2'd3; in_frame = 1'b0; empty_run = 0;
            end else begin
                empty_run++;
            end
        end
        if (accept) begin
            void'(pay_q.pop_front());
            void'(last_q.pop_front());
        end
        if (exp_rd && it.r == R_PAY) begin
            pay_q.push_back(it.b);
            last_q.push_back(it.last);
            mv_exp = 1'b1;
        end else if (accept) begin
            mv_exp = 1'b0;
        end
        ok_exp  = nok;
        err_exp = nerr;
        @(posedge clk);
        #1;
        apply_inputs();
        #1;
        check("frame_ok", frame_ok, ok_exp);
        check("frame_err", frame_err, err_exp);
        check("err_code", err_code, code_exp);
        check("m_valid", m_valid, mv_exp);
        if (mv_exp) begin
            check("m_data", m_data, pay_q[0]);
            check("m_last", m_last, last_q[0]);
        end
    endtask

    task automatic drain(input int budget);
        int  n;
        logic done;
        n = 0;
        while ((fifo.size() != 0 || mv_exp) && n < budget) begin
            cycle();
            n++;
        end
        done = (fifo.size() == 0) && !mv_exp;
        check("drain_done", done, 1'b1);
        cycle();
        cycle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int n;
        int k;

        // Reset with a byte presented: nothing may be popped.
        reset    = 1'b0;
        m_ready  = 1'b1;
        r_data   = SOF_B;
        rx_empty = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_rd_uart", rd_uart, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_m_last", m_last, 1'b0);
        check("rst_frame_ok", frame_ok, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_err_code", err_code, 2'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        apply_inputs();
        #1;
        cycle();

        // 1: good frame A5 03 11 22 33 03
        pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
        push_frame(-1);
        drain(200);

        // 2: same frame with CHK=00
        push_frame(0);
        drain(200);

        // 3: garbage then SOF with LEN=0
        push_byte(8'h00, R_DROP, 1'b0, 1'b1);
        push_byte(8'hFF, R_DROP, 1'b0, 1'b1);
        push_byte(SOF_B, R_SOF, 1'b0, 1'b1);
        push_byte(8'h00, R_LEN, 1'b0, 1'b0);
        drain(200);

        // LEN boundaries: MAX_LEN+1 rejected, MAX_LEN accepted
        push_byte(SOF_B, R_SOF, 1'b0, 1'b1);
        push_byte(8'(MAX_LEN + 1), R_LEN, 1'b0, 1'b0);
        rand_payload(MAX_LEN);
        push_frame(-1);
        drain(2000);

        // 4: backpressure mid-payload longer than the timeout
        rand_payload(10);
        push_frame(-1);
        pay_pops = 0;
        n = 0;
        while (pay_pops < 3 && n < 50) begin cycle(); n++; end
        check("bp_reached_payload", pay_pops >= 3, 1'b1);
        rdy_pct = 0;
        for (int i = 0; i < int'(TIMEOUT) + 20; i++) cycle();
        rdy_pct = 100;
        drain(500);

        // 5: A5 02 11 then silence -> timeout, then a normal frame
        push_byte(SOF_B, R_SOF, 1'b0, 1'b1);
        push_byte(8'h02, R_LEN, 1'b0, 1'b1);
        push_byte(8'h11, R_PAY, 1'b0, 1'b1);
        for (int i = 0; i < int'(TIMEOUT) + 10; i++) cycle();
        check("to_code_held", err_code, 2'd3);
        rand_payload(4);
        push_frame(-1);
        drain(200);

        // 6: asynchronous reset in the middle of DATA
        rand_payload(12);
        push_frame(-1);
        pay_pops = 0;
        n = 0;
        while (pay_pops < 4 && n < 50) begin cycle(); n++; end
        #1;
        reset = 1'b0;
        #1;
        check("arst_rd_uart", rd_uart, 1'b0);
        check("arst_m_valid", m_valid, 1'b0);
        check("arst_m_data", m_data, 8'h00);
        check("arst_m_last", m_last, 1'b0);
        check("arst_frame_ok", frame_ok, 1'b0);
        check("arst_frame_err", frame_err, 1'b0);
        check("arst_err_code", err_code, 2'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        apply_inputs();
        #1;
        pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
        push_frame(-1);
        drain(200);

        // Randomized stream: garbage, good/bad frames, SOF inside payload, random gaps and backpressure
        hide_pct = 20;
        rdy_pct  = 70;
        for (int f = 0; f < 25; f++) begin
            k = $urandom_range(2);
            for (int g = 0; g < k; g++) begin
                b = 8'($urandom);
                if (b == SOF_B) b = 8'h5A;
                push_byte(b, R_DROP, 1'b0, 1'b1);
            end
            if ($urandom_range(9) == 0) begin
                push_byte(SOF_B, R_SOF, 1'b0, 1'b1);
                b = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(255, MAX_LEN + 1));
                push_byte(b, R_LEN, 1'b0, 1'b0);
            end else begin
                rand_payload((f == 3) ? int'(MAX_LEN) : int'($urandom_range(12, 1)));
                if ($urandom_range(1) == 0) pl[0] = SOF_B;
                if ($urandom_range(3) == 0) push_frame(int'($urandom_range(255)));
                else push_frame(-1);
            end
        end
        drain(20000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
